// File: rtl/vliw_dual_port_data_memory_if.sv
// Two-lane load/store bus between the VLIW issue slots and the data memory.
// Lane 1 is the later slot in bundle order.
interface vliw_dual_port_data_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] Address0;
    logic [DATA_WIDTH-1:0] WriteData0;
    logic                  MemWriteEnable0;
    logic                  MemRead0;
    logic [DATA_WIDTH-1:0] ReadData0;
    logic                  ReadValid0;

    logic [ADDR_WIDTH-1:0] Address1;
    logic [DATA_WIDTH-1:0] WriteData1;
    logic                  MemWriteEnable1;
    logic                  MemRead1;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic                  ReadValid1;

    logic                  Ready;

    modport master (
        output Address0, WriteData0, MemWriteEnable0, MemRead0,
        output Address1, WriteData1, MemWriteEnable1, MemRead1,
        input  ReadData0, ReadValid0, ReadData1, ReadValid1, Ready
    );

    modport slave (
        input  Address0, WriteData0, MemWriteEnable0, MemRead0,
        input  Address1, WriteData1, MemWriteEnable1, MemRead1,
        output ReadData0, ReadValid0, ReadData1, ReadValid1, Ready
    );
endinterface

// File: rtl/vliw_dual_port_data_memory.sv
// Dual-lane VLIW data memory: registered write-first loads, lane 1 wins store
// conflicts, and a post-reset clear sweep that holds Ready low until done.
module vliw_dual_port_data_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input logic CLK,
    input logic RST_N,
    vliw_dual_port_data_memory_if.slave bus
);
    localparam int IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(DEPTH - 1);

    typedef enum logic {INIT, RUN} memState_t;

    memState_t             state;
    logic [IdxWidth-1:0]   clearIdx;
    logic                  ready;
    logic [DATA_WIDTH-1:0] readData0, readData1;
    logic                  readValid0, readValid1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  inRange0, inRange1;
    logic [IdxWidth-1:0]   idx0, idx1;
    logic                  storeHit0, storeHit1;
    logic                  sameAddr;
    logic [DATA_WIDTH-1:0] loadData0, loadData1;

    always_comb begin
        inRange0  = {1'b0, bus.Address0} < DepthLimit;
        inRange1  = {1'b0, bus.Address1} < DepthLimit;
        idx0      = bus.Address0[IdxWidth-1:0];
        idx1      = bus.Address1[IdxWidth-1:0];
        storeHit0 = (state == RUN) && bus.MemWriteEnable0 && inRange0;
        storeHit1 = (state == RUN) && bus.MemWriteEnable1 && inRange1;
        sameAddr  = bus.Address0 == bus.Address1;

        // Write-first bypass: lane 1 store has priority over lane 0 store.
        loadData0 = '0;
        if (inRange0) begin
            if (storeHit1 && sameAddr)
                loadData0 = bus.WriteData1;
            else if (storeHit0)
                loadData0 = bus.WriteData0;
            else
                loadData0 = mem[idx0];
        end

        loadData1 = '0;
        if (inRange1) begin
            if (storeHit1)
                loadData1 = bus.WriteData1;
            else if (storeHit0 && sameAddr)
                loadData1 = bus.WriteData0;
            else
                loadData1 = mem[idx1];
        end
    end

    // Array has no reset; the clear sweep owns it while in INIT.
    always_ff @(posedge CLK) begin
        if (state == INIT) begin
            mem[clearIdx] <= '0;
        end else begin
            if (storeHit0)
                mem[idx0] <= bus.WriteData0;
            if (storeHit1)
                mem[idx1] <= bus.WriteData1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= INIT;
            clearIdx   <= '0;
            ready      <= 1'b0;
            readData0  <= '0;
            readData1  <= '0;
            readValid0 <= 1'b0;
            readValid1 <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    readValid0 <= 1'b0;
                    readValid1 <= 1'b0;
                    clearIdx   <= clearIdx + 1'b1;
                    if (clearIdx == LastIdx) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    readValid0 <= bus.MemRead0;
                    readValid1 <= bus.MemRead1;
                    if (bus.MemRead0)
                        readData0 <= loadData0;
                    if (bus.MemRead1)
                        readData1 <= loadData1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReadData0  = readData0;
    assign bus.ReadValid0 = readValid0;
    assign bus.ReadData1  = readData1;
    assign bus.ReadValid1 = readValid1;
    assign bus.Ready      = ready;
endmodule

// File: tb/tb_vliw_dual_port_data_memory.sv
// Bench for the dual-lane data memory: two instances (DEPTH 256 and 200) share
// one stimulus stream and are checked each cycle against an array-based model.
module tb_vliw_dual_port_data_memory;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NI = 2;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;
    logic          we0, we1, rd0, rd1;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    vliw_dual_port_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
    vliw_dual_port_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();

    assign busA.Address0 = a0;  assign busB.Address0 = a0;
    assign busA.WriteData0 = wd0; assign busB.WriteData0 = wd0;
    assign busA.MemWriteEnable0 = we0; assign busB.MemWriteEnable0 = we0;
    assign busA.MemRead0 = rd0; assign busB.MemRead0 = rd0;
    assign busA.Address1 = a1;  assign busB.Address1 = a1;
    assign busA.WriteData1 = wd1; assign busB.WriteData1 = wd1;
    assign busA.MemWriteEnable1 = we1; assign busB.MemWriteEnable1 = we1;
    assign busA.MemRead1 = rd1; assign busB.MemRead1 = rd1;

    vliw_dual_port_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256)) dutA (
        .CLK(CLK), .RST_N(RST_N), .bus(busA)
    );
    vliw_dual_port_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(200)) dutB (
        .CLK(CLK), .RST_N(RST_N), .bus(busB)
    );

    logic [DW-1:0] dRd0 [NI], dRd1 [NI];
    logic          dRv0 [NI], dRv1 [NI], dReady [NI];
    assign dRd0[0] = busA.ReadData0;  assign dRd0[1] = busB.ReadData0;
    assign dRd1[0] = busA.ReadData1;  assign dRd1[1] = busB.ReadData1;
    assign dRv0[0] = busA.ReadValid0; assign dRv0[1] = busB.ReadValid0;
    assign dRv1[0] = busA.ReadValid1; assign dRv1[1] = busB.ReadValid1;
    assign dReady[0] = busA.Ready;    assign dReady[1] = busB.Ready;

    function automatic int depthOf(int i);
        return (i == 0) ? 256 : 200;
    endfunction

    // Model: count clean cycles after reset; once DEPTH have passed the memory
    // is all-zero and ready. Stores apply lane 0 then lane 1, then loads read.
    logic [DW-1:0] mMem [NI][256];
    int            mInit [NI];
    bit            mReady [NI], mRv0 [NI], mRv1 [NI];
    logic [DW-1:0] mRd0 [NI], mRd1 [NI];

    always @(posedge CLK or negedge RST_N) begin
        for (int i = 0; i < NI; i++) begin
            if (!RST_N) begin
                mInit[i] = 0; mReady[i] = 0; mRv0[i] = 0; mRv1[i] = 0;
                mRd0[i] = '0; mRd1[i] = '0;
            end else if (!mReady[i]) begin
                mRv0[i] = 0; mRv1[i] = 0;
                mInit[i] = mInit[i] + 1;
                if (mInit[i] == depthOf(i)) begin
                    mReady[i] = 1;
                    for (int j = 0; j < 256; j++) mMem[i][j] = '0;
                end
            end else begin
                if (we0 && int'(a0) < depthOf(i)) mMem[i][a0] = wd0;
                if (we1 && int'(a1) < depthOf(i)) mMem[i][a1] = wd1;
                mRv0[i] = rd0;
                mRv1[i] = rd1;
                if (rd0) mRd0[i] = (int'(a0) < depthOf(i)) ? mMem[i][a0] : '0;
                if (rd1) mRd1[i] = (int'(a1) < depthOf(i)) ? mMem[i][a1] : '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model.Ready[%0d]", i), 32'(dReady[i]), 32'(mReady[i]));
                chk($sformatf("model.ReadValid0[%0d]", i), 32'(dRv0[i]), 32'(mRv0[i]));
                chk($sformatf("model.ReadValid1[%0d]", i), 32'(dRv1[i]), 32'(mRv1[i]));
                chk($sformatf("model.ReadData0[%0d]", i), 32'(dRd0[i]), 32'(mRd0[i]));
                chk($sformatf("model.ReadData1[%0d]", i), 32'(dRd1[i]), 32'(mRd1[i]));
            end
        end
    end

    task automatic idle();
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
        we0 = 0; we1 = 0; rd0 = 0; rd1 = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic waitReady(input string tag);
        int nA = 0;
        int nB = 0;
        for (int n = 1; n <= 400 && nA == 0; n++) begin
            tick();
            if (dReady[0] && nA == 0) nA = n;
            if (dReady[1] && nB == 0) nB = n;
        end
        chk({tag, ".readyLatency256"}, 32'(nA), 32'd256);
        chk({tag, ".readyLatency200"}, 32'(nB), 32'd200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #1 RST_N = 1'b0;
        #1 checking = 1'b1;
        chk("reset.Ready", 32'(dReady[0]), 32'd0);
        chk("reset.ReadValid0", 32'(dRv0[0]), 32'd0);
        chk("reset.ReadData0", 32'(dRd0[0]), 32'd0);
        tick(); tick();
        RST_N = 1'b1;
        waitReady("init");

        // Every address reads back cleared on both lanes.
        for (int i = 0; i < 256; i++) begin
            rd0 = 1; a0 = AW'(i);
            rd1 = 1; a1 = AW'(255 - i);
            tick();
            chk("sweep.ReadValid0", 32'(dRv0[0]), 32'd1);
            chk("sweep.ReadData0", 32'(dRd0[0]), 32'h00);
            chk("sweep.ReadData1", 32'(dRd1[0]), 32'h00);
        end
        idle(); tick();

        // Independent lane stores, then crossed loads.
        we0 = 1; a0 = 8'h00; wd0 = 8'hFF;
        we1 = 1; a1 = 8'h10; wd1 = 8'h5A;
        tick(); idle();
        rd0 = 1; a0 = 8'h10;
        rd1 = 1; a1 = 8'h00;
        tick(); idle();
        chk("cross.ReadData0", 32'(dRd0[0]), 32'h5A);
        chk("cross.ReadData1", 32'(dRd1[0]), 32'hFF);
        chk("cross.ReadValid0", 32'(dRv0[0]), 32'd1);
        chk("cross.ReadValid1", 32'(dRv1[0]), 32'd1);
        tick();
        chk("cross.pulse0", 32'(dRv0[0]), 32'd0);
        chk("cross.pulse1", 32'(dRv1[0]), 32'd0);
        chk("cross.hold0", 32'(dRd0[0]), 32'h5A);

        // Same-address store conflict with a same-cycle load.
        we0 = 1; a0 = 8'h20; wd0 = 8'h11; rd0 = 1;
        we1 = 1; a1 = 8'h20; wd1 = 8'h22;
        tick(); idle();
        chk("conflict.bypass", 32'(dRd0[0]), 32'h22);
        rd1 = 1; a1 = 8'h20;
        tick(); idle();
        chk("conflict.stored", 32'(dRd1[0]), 32'h22);

        // Store not enabled leaves the earlier value.
        we0 = 1; a0 = 8'h05; wd0 = 8'hAA;
        tick(); idle();
        a0 = 8'h05; wd0 = 8'h33;
        tick(); idle();
        rd0 = 1; a0 = 8'h05;
        tick(); idle();
        chk("noWrite.ReadData0", 32'(dRd0[0]), 32'hAA);

        // Load and store on one lane returns the stored value.
        we1 = 1; rd1 = 1; a1 = 8'h40; wd1 = 8'h3C;
        tick(); idle();
        chk("sameLane.ReadData1", 32'(dRd1[0]), 32'h3C);

        // Out-of-range for the 200-word instance only.
        we0 = 1; a0 = 8'hF0; wd0 = 8'h77;
        tick(); idle();
        rd0 = 1; a0 = 8'hF0;
        rd1 = 1; a1 = 8'hC7;
        tick(); idle();
        chk("oor.B.ReadData0", 32'(dRd0[1]), 32'h00);
        chk("oor.B.ReadValid0", 32'(dRv0[1]), 32'd1);
        chk("oor.B.lastWord", 32'(dRd1[1]), 32'h00);
        chk("oor.A.ReadData0", 32'(dRd0[0]), 32'h77);

        // Reset with a load pending discards it and restarts the clear.
        we0 = 1; a0 = 8'h03; wd0 = 8'h99;
        tick(); idle();
        rd0 = 1; a0 = 8'h03;
        #2 RST_N = 1'b0;
        #1;
        chk("midReset.ReadData0", 32'(dRd0[0]), 32'h00);
        chk("midReset.ReadValid0", 32'(dRv0[0]), 32'd0);
        chk("midReset.Ready", 32'(dReady[0]), 32'd0);
        tick();
        chk("midReset.noPulse", 32'(dRv0[0]), 32'd0);
        idle(); tick();
        RST_N = 1'b1;
        waitReady("reinit");
        rd0 = 1; a0 = 8'h03;
        tick(); idle();
        chk("reinit.ReadData0", 32'(dRd0[0]), 32'h00);
        chk("reinit.ReadValid0", 32'(dRv0[0]), 32'd1);
        tick(); tick();

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vliw_dual_port_data_memory.md
Name: vliw_dual_port_data_memory

Overview:
Two-lane data memory for the VLIW datapath, replacing the single-port data memory. Both issue slots of a bundle can load/store in the same cycle. Width and depth are parametrised. Reads are registered with a valid flag. A hardware clear sequence runs after reset, and a ready output gates access until it completes.

Parameters:
DATA_WIDTH, 8, width of each memory word and data port
ADDR_WIDTH, 8, width of each address port
DEPTH, 256, number of words; DEPTH <= 2**ADDR_WIDTH

Ports:
CLK  input  1  clock, all state changes on rising edge
RST_N  input  1  asynchronous active-low reset
Address0  input  ADDR_WIDTH  lane 0 word address
WriteData0  input  DATA_WIDTH  lane 0 store data
MemWriteEnable0  input  1  lane 0 store request
MemRead0  input  1  lane 0 load request
ReadData0  output  DATA_WIDTH  lane 0 registered load data
ReadValid0  output  1  lane 0 load data valid, one-cycle pulse
Address1  input  ADDR_WIDTH  lane 1 word address
WriteData1  input  DATA_WIDTH  lane 1 store data
MemWriteEnable1  input  1  lane 1 store request
MemRead1  input  1  lane 1 load request
ReadData1  output  DATA_WIDTH  lane 1 registered load data
ReadValid1  output  1  lane 1 load data valid, one-cycle pulse
Ready  output  1  high once clear sequence done; accesses honoured only when high

Behaviour:
- Reset (RST_N low, asynchronous):
  - ReadData0/1 = 0, ReadValid0/1 = 0, Ready = 0.
  - State = INIT, clear counter = 0.
  - Array contents are not reset directly.
- Reset mid-INIT or mid-RUN: same as above, takes effect immediately. The clear restarts from word 0. Any in-flight read is discarded, so no ReadValid pulse.
- State INIT:
  - Each rising edge writes 0 to mem[counter] and increments counter.
  - On the edge that writes word DEPTH-1, state -> RUN and Ready -> 1. Ready is first high DEPTH cycles after reset release.
  - Lane requests are ignored: stores dropped, loads produce no ReadValid.
- State RUN, stores:
  - Occur at the rising edge where MemWriteEnable is high and Address < DEPTH.
  - Address >= DEPTH: store dropped silently.
- Store conflict (both lanes store to the same address in one cycle): lane 1 data is written. Lane 1 is the later slot in bundle order.
- State RUN, loads:
  - MemRead sampled at the rising edge.
  - ReadData updated at that same edge, visible the following cycle (latency 1).
  - ReadValid high for exactly that one cycle.
  - Back-to-back loads give back-to-back valid data.
- Read-during-write is write-first: a load in the same cycle as a store to the same address (either lane) returns the newly stored value. If both lanes store there, the load returns lane 1 data.
- Out-of-range load (Address >= DEPTH): ReadData = 0, ReadValid = 1.
- No load in a cycle: ReadData holds its previous value, ReadValid = 0.
- MemRead and MemWriteEnable both high on one lane: both performed; the load returns WriteData (write-first).
- Lanes are fully independent except for the conflict and bypass rules above. No stalls and no backpressure.

Test Plan:
1. Reset, DATA_WIDTH=8, DEPTH=256 -> Ready low for exactly 256 cycles after RST_N rises. Then a load of every address -> 0x00 with ReadValid=1.
2. After Ready: lane 0 stores 0xFF @0x00 and lane 1 stores 0x5A @0x10. Next cycle, lane 0 loads 0x10 and lane 1 loads 0x00 -> one cycle later ReadData0=0x5A, ReadData1=0xFF, both ReadValid=1 for one cycle only.
3. Both lanes store to 0x20 (lane 0: 0x11, lane 1: 0x22) while lane 0 loads 0x20 the same cycle -> ReadData0=0x22 next cycle. A later load of 0x20 also returns 0x22.
4. Store 0x33 with MemWriteEnable0=0 after writing 0xAA @0x05 -> a load of 0x05 returns 0xAA, not 0x33.
5. DEPTH=200: store 0x77 @0xF0, then load 0xF0 -> ReadData=0x00, ReadValid=1. A load of 0xC7 -> 0x00 (cleared, unaffected).
6. Store 0x99 @0x03, assert RST_N low mid-cycle with a load pending -> outputs 0 immediately, no ReadValid. After 256 cycles Ready=1, and a load of 0x03 returns 0x00.
